// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier initiator, the multiplier and their benches.
package mult_pkg;
  localparam int WIDTH_DEF   = 5;
  localparam int TIMEOUT_DEF = 64;
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;
endpackage

// File: rtl/mult_initiator_if.sv
// Operand, multiplier and result channels of the multiplier initiator.
interface mult_initiator_if import mult_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  // Handshakes: op and res transfer on a clock edge where valid and ready are both high;
  // m_req stays high with stable m_a/m_b until m_rdy is sampled high, m_ab is valid only with m_done.
  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               m_req;
  logic [WIDTH-1:0]   m_a;
  logic [WIDTH-1:0]   m_b;
  logic               m_rdy;
  logic               m_done;
  logic [2*WIDTH-1:0] m_ab;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_ab;
  logic               res_err;

  modport master (
    input  op_valid, op_a, op_b, m_rdy, m_done, m_ab, res_ready,
    output op_ready, m_req, m_a, m_b, res_valid, res_ab, res_err
  );

  modport slave (
    output op_valid, op_a, op_b, m_rdy, m_done, m_ab, res_ready,
    input  op_ready, m_req, m_a, m_b, res_valid, res_ab, res_err
  );
endinterface

// File: rtl/mult_wd_counter.sv
// Watchdog for the WAIT state: synchronous clear, count enable, terminal count at TIMEOUT-1.
module mult_wd_counter import mult_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [WD_W-1:0] count,
  output logic            tc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WD_W'(TIMEOUT - 1));
endmodule

// File: rtl/mult_initiator.sv
// Issues one operand pair to an external multiplier, waits for its product with a
// watchdog, and holds the product (or a timeout abort) until downstream accepts it.
module mult_initiator import mult_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mult_initiator_if.master  bus,
  output logic              busy,
  output logic [15:0]       txn_count,
  output state_t            state
);
  state_t            state_q;
  state_t            state_d;
  logic              capture;
  logic              abort;
  logic              wd_clear;
  logic              wd_en;
  logic              wd_tc;
  logic [WD_W-1:0]   wd_count;

  mult_wd_counter #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .count  (wd_count),
    .tc     (wd_tc)
  );

  assign wd_en        = (state_q == WAIT);
  assign bus.op_ready = (state_q == IDLE);
  assign state        = state_q;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    abort    = 1'b0;
    wd_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) state_d = REQ;
      end
      REQ: begin
        // m_done without m_rdy is not a response to this request.
        if (bus.m_rdy) begin
          if (bus.m_done) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            wd_clear = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.m_done) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (wd_tc) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bus.m_req     <= 1'b0;
      bus.m_a       <= '0;
      bus.m_b       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_ab    <= '0;
      bus.res_err   <= 1'b0;
      busy          <= 1'b0;
      txn_count     <= '0;
    end else begin
      state_q       <= state_d;
      bus.m_req     <= (state_d == REQ);
      bus.res_valid <= (state_d == HOLD);
      busy          <= (state_d != IDLE);
      if (state_q == IDLE && bus.op_valid) begin
        bus.m_a <= bus.op_a;
        bus.m_b <= bus.op_b;
      end
      if (capture) begin
        bus.res_ab  <= bus.m_ab;
        bus.res_err <= 1'b0;
      end else if (abort) begin
        bus.res_ab  <= '0;
        bus.res_err <= 1'b1;
      end
      if (state_q == HOLD && bus.res_ready) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mult_initiator.sv
// Directed and random transactions against mult_initiator with a modelled multiplier responder.
module tb_mult_initiator;
  import mult_pkg::*;

  localparam int WIDTH   = 5;
  localparam int TIMEOUT = 8;
  localparam int PW      = 2 * WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] txn_count;
  state_t      state;

  mult_initiator_if #(.WIDTH(WIDTH)) bus ();

  mult_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count),
    .state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {err, ab}
  logic [PW:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_txn = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
    check({tag, "_m_req"}, 32'(bus.m_req), 0);
    check({tag, "_m_a"}, 32'(bus.m_a), 0);
    check({tag, "_m_b"}, 32'(bus.m_b), 0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_res_ab"}, 32'(bus.res_ab), 0);
    check({tag, "_res_err"}, 32'(bus.res_err), 0);
    check({tag, "_txn"}, 32'(txn_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_op_ready"}, 32'(bus.op_ready), 1);
  endtask

  // done_dly: -1 never, 0 with m_rdy, d>0 in the d-th cycle after the m_rdy cycle
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int rdy_dly, input int done_dly, input int hold);
    logic [PW-1:0] prod;
    logic [PW:0]   exp_v;
    logic          err;
    int            n;
    prod = PW'(a) * PW'(b);
    err  = (done_dly < 0) || (done_dly > TIMEOUT);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    n = 0;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_ready", 32'(bus.op_ready), 1);
    exp_q.push_back(err ? {1'b1, {PW{1'b0}}} : {1'b0, prod});
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("m_req_on", 32'(bus.m_req), 1);
    check("m_a", 32'(bus.m_a), 32'(a));
    check("m_b", 32'(bus.m_b), 32'(b));
    check("op_ready_lo", 32'(bus.op_ready), 0);
    repeat (rdy_dly) @(negedge clk);
    bus.m_rdy = 1'b1;
    if (done_dly == 0) begin
      bus.m_done = 1'b1;
      bus.m_ab   = prod;
    end
    @(negedge clk);
    bus.m_rdy  = 1'b0;
    bus.m_done = 1'b0;
    check("m_req_off", 32'(bus.m_req), 0);
    if (done_dly > 0 && !err) begin
      repeat (done_dly - 1) @(negedge clk);
      bus.m_done = 1'b1;
      bus.m_ab   = prod;
      @(negedge clk);
      bus.m_done = 1'b0;
    end
    n = 0;
    while (!bus.res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", 32'(bus.res_valid), 1);
    if (err) check("timeout_latency", 32'(n), TIMEOUT);
    else     check("done_latency", 32'(n), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.res_valid), 1);
      check("hold_ab", 32'(bus.res_ab), 32'(exp_q[0][PW-1:0]));
      check("hold_op_ready", 32'(bus.op_ready), 0);
      check("hold_m_req", 32'(bus.m_req), 0);
      check("hold_txn", 32'(txn_count), 32'(exp_txn));
    end
    bus.res_ready = 1'b1;
    check("sb_depth", 32'(exp_q.size()), 1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("res_ab", 32'(bus.res_ab), 32'(exp_v[PW-1:0]));
      check("res_err", 32'(bus.res_err), 32'(exp_v[PW]));
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_txn++;
    check("txn_count", 32'(txn_count), 32'(exp_txn));
    check("busy_idle", 32'(busy), 0);
    check("res_valid_lo", 32'(bus.res_valid), 0);
  endtask

  task automatic spurious_done;
    @(negedge clk);
    bus.m_done = 1'b1;
    bus.m_ab   = PW'(5);
    @(negedge clk);
    bus.m_done = 1'b0;
    check("spur_state", 32'(state), 32'(IDLE));
    check("spur_res_valid", 32'(bus.res_valid), 0);
    check("spur_busy", 32'(busy), 0);
    check("spur_txn", 32'(txn_count), 32'(exp_txn));
  endtask

  task automatic reset_in_wait;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a     = WIDTH'(3);
    bus.op_b     = WIDTH'(4);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.m_rdy    = 1'b1;
    @(negedge clk);
    bus.m_rdy = 1'b0;
    @(negedge clk);
    check("rst_pre_state", 32'(state), 32'(WAIT));
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    exp_txn = '0;
    @(negedge clk);
    rst        = 1'b0;
    bus.m_done = 1'b1;
    bus.m_ab   = PW'(12);
    @(negedge clk);
    bus.m_done = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_res_valid", 32'(bus.res_valid), 0);
    check("post_rst_state", 32'(state), 32'(IDLE));
    check("post_rst_txn", 32'(txn_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.m_rdy     = 1'b0;
    bus.m_done    = 1'b0;
    bus.m_ab      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    spurious_done();
    run_txn(WIDTH'(7), WIDTH'(9), 2, 3, 0);
    run_txn(WIDTH'(31), WIDTH'(31), 0, 0, 0);
    run_txn(WIDTH'(12), WIDTH'(5), 1, -1, 0);
    run_txn(WIDTH'(6), WIDTH'(11), 0, 2, 5);
    run_txn(WIDTH'(21), WIDTH'(17), 0, TIMEOUT, 0);
    run_txn(WIDTH'(2), WIDTH'(3), 0, -1, 5);
    for (int i = 0; i < 8; i++) begin
      run_txn(WIDTH'($urandom_range(0, 31)), WIDTH'($urandom_range(0, 31)),
              $urandom_range(0, 3), $urandom_range(0, 10) - 1, $urandom_range(0, 3));
    end
    spurious_done();
    reset_in_wait();
    run_txn(WIDTH'(13), WIDTH'(29), 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
